sat_sub_serial_16: RTL and testbench

//   Multi-cycle saturating two's-complement subtractor: Diff = sat(A - B).

---
 rtl/sat_sub_serial_16_if.sv | 22 ++
 rtl/sat_sub_serial_16.sv | 140 ++++++++++++++
 tb/tb_sat_sub_serial_16.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sat_sub_serial_16_if.sv
// Handshake and operand/result bundle for the serial saturating subtractor.
interface sat_sub_serial_16_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Ovfl;

  modport master (
    output start, A, B,
    input  busy, done, Diff, Ovfl
  );

  modport slave (
    input  start, A, B,
    output busy, done, Diff, Ovfl
  );
endinterface

// File: rtl/sat_sub_serial_16.sv
// Multi-cycle saturating subtractor: Diff = sat(A - B), STEP bits per clock,
// LSB slice first, computed as A + ~B + 1 under a start/busy/done handshake.
module sat_sub_serial_16 #(
  parameter int WIDTH = 16,
  parameter int STEP  = 4
) (
  input logic                clk,
  input logic                rst_n,
  sat_sub_serial_16_if.slave bus
);

  localparam int NSTEP = WIDTH / STEP;
  localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state_r;
  state_t                 state_nx_s;
  logic                   accept_s;
  logic                   last_s;
  logic [WIDTH-1:0]       a_r;
  logic [WIDTH-1:0]       b_r;
  logic [WIDTH-STEP-1:0]  part_r;
  logic                   carry_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   busy_r;
  logic                   done_r;
  logic [WIDTH-1:0]       diff_r;
  logic                   ovfl_r;
  logic [STEP:0]          slice_sum_s;
  logic                   cin_msb_s;
  logic                   ovfl_s;
  logic [WIDTH-1:0]       raw_s;

  // Clamp to the representable extreme on the side of the minuend's sign.
  function automatic logic [WIDTH-1:0] sat_value(
    input logic             ovfl,
    input logic             a_sign,
    input logic [WIDTH-1:0] raw
  );
    if (!ovfl) begin
      return raw;
    end else if (a_sign) begin
      return {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      return {1'b0, {(WIDTH-1){1'b1}}};
    end
  endfunction

  // Current slice adder; operands are shifted so the active slice sits at bit 0.
  always_comb begin
    slice_sum_s = {1'b0, a_r[STEP-1:0]} + {1'b0, ~b_r[STEP-1:0]} + {{STEP{1'b0}}, carry_r};
    cin_msb_s   = slice_sum_s[STEP-1] ^ a_r[STEP-1] ^ ~b_r[STEP-1];
    ovfl_s      = slice_sum_s[STEP] ^ cin_msb_s;
    raw_s       = {slice_sum_s[STEP-1:0], part_r};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and accept/last-slice decode.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          accept_s   = 1'b1;
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_W'(NSTEP - 1)) begin
          last_s     = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RUN;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Operand capture, slice accumulation and result load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      part_r  <= {(WIDTH-STEP){1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      diff_r  <= {WIDTH{1'b0}};
      ovfl_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept_s) begin
        a_r     <= bus.A;
        b_r     <= bus.B;
        carry_r <= 1'b1;
        cnt_r   <= {CNT_W{1'b0}};
        busy_r  <= 1'b1;
      end else if (state_r == RUN) begin
        a_r     <= a_r >> STEP;
        b_r     <= b_r >> STEP;
        part_r  <= raw_s[WIDTH-1:STEP];
        carry_r <= slice_sum_s[STEP];
        cnt_r   <= cnt_r + CNT_W'(1);
        // On the last slice a_r[STEP-1] is the original sign bit of A.
        if (last_s) begin
          diff_r <= sat_value(ovfl_s, a_r[STEP-1], raw_s);
          ovfl_r <= ovfl_s;
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.Diff = diff_r;
  assign bus.Ovfl = ovfl_r;

endmodule

// File: tb/tb_sat_sub_serial_16.sv
// Self-checking bench for sat_sub_serial_16 against a plain-integer saturating model.
module tb_sat_sub_serial_16;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  sat_sub_serial_16_if #(.WIDTH(16)) bus ();

  sat_sub_serial_16 #(.WIDTH(16), .STEP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed difference in plain integers, clamped to the 16-bit range.
  function automatic void ref_model(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] d, output logic o);
    int diff;
    diff = int'($signed(a)) - int'($signed(b));
    if (diff > 32767) begin
      d = 16'h7FFF; o = 1'b1;
    end else if (diff < -32768) begin
      d = 16'h8000; o = 1'b1;
    end else begin
      d = 16'(diff); o = 1'b0;
    end
  endfunction

  // Issue one operation and wait (bounded) for done; returns result and edge count.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] d, output logic o, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A = 16'($urandom); bus.B = 16'($urandom);
    lat = 0;
    d = 16'h0; o = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) begin
        d = bus.Diff; o = bus.Ovfl;
        break;
      end
    end
    if (!bus.done) lat = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.start = 1'b0; bus.A = 16'h0; bus.B = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({bus.busy, bus.done, bus.Diff, bus.Ovfl} !== 19'h0) begin
      $display("FAIL reset_state: got busy=%b done=%b Diff=%h Ovfl=%b want all 0",
               bus.busy, bus.done, bus.Diff, bus.Ovfl);
    end else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_nominal;
    int lat_busy;
    @(negedge clk);
    bus.start = 1'b1; bus.A = 16'h0005; bus.B = 16'h0003;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.A = 16'hFFFF; bus.B = 16'hAAAA;
    lat_busy = 0;
    for (int i = 1; i <= 4; i++) begin
      if (bus.busy === 1'b1 && bus.done === 1'b0) lat_busy++;
      if (i < 4) begin @(posedge clk); #1; end
    end
    total_cnt++;
    if (lat_busy != 4) $display("FAIL nominal_busy: busy-without-done cycles %0d want 4", lat_busy);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({bus.done, bus.busy, bus.Diff, bus.Ovfl} !== {1'b1, 1'b0, 16'h0002, 1'b0})
      $display("FAIL nominal_result: done=%b busy=%b Diff=%h Ovfl=%b want 1 0 0002 0",
               bus.done, bus.busy, bus.Diff, bus.Ovfl);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.done !== 1'b0) $display("FAIL nominal_done_pulse: done=%b want 0", bus.done);
    else pass_cnt++;
  endtask

  task automatic test_arith;
    logic [15:0] va [8] = '{16'h7FFF, 16'h0000, 16'h8000, 16'h1000, 16'h8000, 16'h1234, 16'hABCD, 16'h8001};
    logic [15:0] vb [8] = '{16'hFFFF, 16'h8000, 16'h0001, 16'h0001, 16'h8000, 16'h1234, 16'h0000, 16'h7FFF};
    logic [15:0] a, b, d, ed;
    logic o, eo;
    int lat;
    for (int i = 0; i < 48; i++) begin
      if (i < 8) begin
        a = va[i]; b = vb[i];
      end else begin
        a = 16'($urandom); b = 16'($urandom);
        if (i % 8 == 0) b = 16'h0000;
        if (i % 8 == 1) b = a;
        if (i % 8 == 2) a = {1'b0, a[14:0]} | 16'h4000;
        if (i % 8 == 3) b = {1'b1, b[14:0]} & 16'hBFFF;
      end
      ref_model(a, b, ed, eo);
      run_op(a, b, d, o, lat);
      total_cnt++;
      if (lat != 4 || d !== ed || o !== eo)
        $display("FAIL arith: A=%h B=%h got Diff=%h Ovfl=%b lat=%0d want Diff=%h Ovfl=%b lat=4",
                 a, b, d, o, lat, ed, eo);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    bus.start = 1'b1; bus.A = 16'h0010; bus.B = 16'h0001;
    @(posedge clk); #1;                                   // E0
    bus.start = 1'b0; bus.A = 16'h5555; bus.B = 16'h5555;
    @(posedge clk); #1;                                   // E1
    bus.start = 1'b1; bus.A = 16'h1111; bus.B = 16'h2222;
    @(posedge clk); #1;                                   // E2
    bus.start = 1'b0;
    @(posedge clk); #1;                                   // E3
    bus.start = 1'b1; bus.A = 16'h1111; bus.B = 16'h2222;
    @(posedge clk); #1;                                   // E4
    total_cnt++;
    if ({bus.done, bus.busy, bus.Diff, bus.Ovfl} !== {1'b1, 1'b0, 16'h000F, 1'b0})
      $display("FAIL b2b_first: done=%b busy=%b Diff=%h Ovfl=%b want 1 0 000F 0",
               bus.done, bus.busy, bus.Diff, bus.Ovfl);
    else pass_cnt++;
    bus.A = 16'h0003; bus.B = 16'h0005;
    @(posedge clk); #1;                                   // E5 accept
    bus.start = 1'b0; bus.A = 16'h7777; bus.B = 16'h8888;
    total_cnt++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0)
      $display("FAIL b2b_accept: busy=%b done=%b want 1 0", bus.busy, bus.done);
    else pass_cnt++;
    repeat (4) @(posedge clk);                            // E9
    #1;
    total_cnt++;
    if ({bus.done, bus.Diff, bus.Ovfl} !== {1'b1, 16'hFFFE, 1'b0})
      $display("FAIL b2b_second: done=%b Diff=%h Ovfl=%b want 1 FFFE 0",
               bus.done, bus.Diff, bus.Ovfl);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [15:0] d;
    logic o;
    int lat;
    int seen_done;
    @(negedge clk);
    bus.start = 1'b1; bus.A = 16'h7FFF; bus.B = 16'hFFFF;
    @(posedge clk); #1;                                   // E0
    bus.start = 1'b0;
    repeat (2) @(posedge clk);                            // E2
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.busy, bus.done, bus.Diff, bus.Ovfl} !== 19'h0)
      $display("FAIL reset_mid: busy=%b done=%b Diff=%h Ovfl=%b want all 0",
               bus.busy, bus.done, bus.Diff, bus.Ovfl);
    else pass_cnt++;
    seen_done = 0;
    repeat (3) begin @(negedge clk); if (bus.done) seen_done++; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (bus.done) seen_done++; end
    total_cnt++;
    if (seen_done != 0) $display("FAIL reset_no_done: done seen %0d times want 0", seen_done);
    else pass_cnt++;
    run_op(16'h0009, 16'h0009, d, o, lat);
    total_cnt++;
    if (lat != 4 || d !== 16'h0000 || o !== 1'b0)
      $display("FAIL reset_recover: Diff=%h Ovfl=%b lat=%0d want 0000 0 4", d, o, lat);
    else pass_cnt++;
  endtask

  task automatic test_hold;
    logic [15:0] d, ed;
    logic o, eo;
    int lat;
    int bad;
    ref_model(16'h8000, 16'h0001, ed, eo);
    run_op(16'h8000, 16'h0001, d, o, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.A = 16'($urandom); bus.B = 16'($urandom);
      @(posedge clk); #1;
      if (bus.Diff !== ed || bus.Ovfl !== eo || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0 || d !== ed)
      $display("FAIL hold: %0d bad cycles, Diff=%h Ovfl=%b busy=%b want Diff=%h Ovfl=%b busy=0",
               bad, bus.Diff, bus.Ovfl, bus.busy, ed, eo);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_nominal();
    test_arith();
    test_back_to_back();
    test_reset_mid();
    test_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
